// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B-Bin, LSB first, one bit/clk; in clk rst start A B Bin, out busy done Diff Borrow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d, r_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, borrow_q, borrow_d, busy_q, busy_d, done_q, done_d, d, bo, last;
  assign d = a_q[0] ^ b_q[0] ^ br_q;
  assign bo = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign r_nx = (r_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    br_d = br_q;
    cnt_d = cnt_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        a_d = A;
        b_d = B;
        br_d = Bin;
        cnt_d = '0;
        busy_d = 1'b1;
        state_d = SHIFT;
      end
    end else begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      r_d = r_nx;
      br_d = bo;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        diff_d = r_nx;
        borrow_d = bo;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      br_q <= 1'b0;
      cnt_q <= '0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      br_q <= br_d;
      cnt_q <= cnt_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor at WIDTH 8, 3 and 1
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic st8 = 1'b0, bin8 = 1'b0, busy8, done8, bo8;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic st3 = 1'b0, bin3 = 1'b0, busy3, done3, bo3;
  logic [2:0] a3 = '0, b3 = '0, d3;
  logic st1 = 1'b0, bin1 = 1'b0, busy1, done1, bo1;
  logic [0:0] a1 = '0, b1 = '0, d1;
  int n_cmp = 0, n_err = 0;
  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .Diff(d8), .Borrow(bo8));
  serial_subtractor #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .start(st3), .A(a3), .B(b3), .Bin(bin3),
    .busy(busy3), .done(done3), .Diff(d3), .Borrow(bo3));
  serial_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1), .Bin(bin1),
    .busy(busy1), .done(done1), .Diff(d1), .Borrow(bo1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb, input bit glitch);
    logic [7:0] prev;
    prev = d8;
    a8 = a;
    b8 = b;
    bin8 = bin;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    check("busy_e0", busy8, 1);
    for (int i = 1; i < 8; i++) begin
      if (glitch && i == 3) begin
        st8 = 1'b1;
        a8 = 8'h01;
        b8 = 8'h02;
      end else st8 = 1'b0;
      tick();
      check("busy_mid", busy8, 1);
      check("done_mid", done8, 0);
      check("diff_hold", d8, prev);
    end
    st8 = 1'b0;
    tick();
    check("done_end", done8, 1);
    check("busy_end", busy8, 0);
    check("diff8", d8, ed);
    check("borrow8", bo8, eb);
  endtask
  initial begin
    logic [7:0] prev, tt_d, tt_b;
    logic [4:0] e3;
    int pulses, last_c;
    bit seen;
    repeat (2) tick();
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", d8, 0);
    check("rst_borrow", bo8, 0);
    check("rst_w3", {busy3, done3, bo3, d3}, 0);
    check("rst_w1", {busy1, done1, bo1, d1}, 0);
    rst = 1'b0;
    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    tick();
    check("done_one_cycle", done8, 0);
    check("diff_keep", d8, 8'h1E);
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    prev = d8;
    a8 = 8'h33;
    b8 = 8'h11;
    bin8 = 1'b0;
    st8 = 1'b1;
    pulses = 0;
    last_c = 0;
    for (int c = 1; c <= 40 && pulses < 3; c++) begin
      tick();
      if (done8) begin
        pulses++;
        check("cont_diff", d8, 8'h22);
        if (pulses > 1) check("cont_period", c - last_c, 9);
        last_c = c;
        prev = d8;
      end else check("cont_stable", d8, prev);
    end
    check("cont_pulses", pulses, 3);
    st8 = 1'b0;
    tick();
    a8 = 8'h5A;
    b8 = 8'h3C;
    st8 = 1'b1;
    tick();
    st8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_diff", d8, 0);
    check("abort_borrow", bo8, 0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (done8) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int bin = 0; bin < 2; bin++) begin
          a3 = 3'(a);
          b3 = 3'(b);
          bin3 = bin[0];
          st3 = 1'b1;
          tick();
          st3 = 1'b0;
          repeat (3) tick();
          e3 = {1'b0, 1'b1, (a < b + bin) ? 1'b1 : 1'b0, 3'(a - b - bin)};
          check("w3", {busy3, done3, bo3, d3}, e3);
        end
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;
    for (int k = 0; k < 8; k++) begin
      a1 = k[2];
      b1 = k[1];
      bin1 = k[0];
      st1 = 1'b1;
      tick();
      st1 = 1'b0;
      tick();
      check("w1", {busy1, done1, bo1, d1}, {1'b0, 1'b1, tt_b[k], tt_d[k]});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes Diff = A − B − Bin using a single full-subtractor cell (Diff = a⊕b⊕bin, Borrow = ~a·b + ~(a⊕b)·bin) and a registered borrow, one bit per clock, LSB first. It sits directly downstream of the combinational full-subtractor cell in the arithmetic library. It is the area-minimal alternative to a ripple-borrow array, and feeds result-consuming logic through a start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1–32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled on the rising edge.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- Bin  input  1  initial borrow-in; captured on the accepting edge.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when Diff/Borrow update.
- Diff  output  WIDTH  registered result, A − B − Bin mod 2^WIDTH.
- Borrow  output  1  registered final borrow-out; 1 iff A < B + Bin.

## Operation
- FSM states:
  - IDLE: waiting for start.
  - SHIFT: computing, one bit per cycle.
- Reset (rst=1 at an edge): state←IDLE; busy, done, Diff, Borrow, internal shift registers, borrow register and bit counter all ←0. Reset has priority over every other event.
- IDLE, start=1:
  - Load internal A_sh←A, B_sh←B, br←Bin, cnt←0.
  - busy←1; state←SHIFT.
- IDLE, start=0: hold; done←0.
- SHIFT, each edge:
  - Compute d and bo from A_sh[0], B_sh[0], br with the full-subtractor equations.
  - Shift A_sh and B_sh right by 1; shift d into the MSB of internal result register R (shift right).
  - br←bo; cnt←cnt+1.
- SHIFT, edge where cnt==WIDTH−1 (the last bit):
  - Diff←final R value, including this bit; Borrow←bo.
  - done←1; busy←0; state←IDLE.
- done is high for exactly one cycle per completed operation.
- Diff and Borrow hold the last completed result at all other times. They do not change during SHIFT.
- start while in SHIFT: ignored. No queueing and no restart.
- start high in the cycle done is high: accepted, because the state is already IDLE. This gives back-to-back operation with no dead cycle.
- A, B and Bin are don't-care except on the accepting edge.
- cnt width: $clog2(WIDTH)+1 bits. It never wraps within an operation.

## Timing
- Accepting edge E0: busy is high from E0 onward.
- WIDTH SHIFT edges follow, E1..E_WIDTH. Diff, Borrow and done update at E_WIDTH; busy falls at E_WIDTH.
- Latency is WIDTH clocks from the accepting edge to results valid. Throughput is one operation per WIDTH+1 clocks with start held continuously (IDLE accept edge + WIDTH shift edges).
- WIDTH=1: the result appears at E1, one cycle after acceptance.
- Reset asserted mid-SHIFT: the operation is aborted at that edge; no done pulse; outputs read 0 the next cycle. start is ignored on any edge where rst=1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, Bin=0, start pulsed one cycle -> busy high 8 cycles; at the 8th edge after acceptance Diff=0x1E, Borrow=0, done high for exactly one cycle.
- WIDTH=8, A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Borrow=1. Then A=0x10, B=0x10, Bin=1 -> Diff=0xFF, Borrow=1. Then A=0xFF, B=0x00, Bin=0 -> Diff=0xFF, Borrow=0.
- start re-asserted at cycle 3 of an operation with different A/B -> ignored; the result matches the first operands. start held high continuously -> a new acceptance on each done cycle, done period 9 clocks, Diff stable between done pulses.
- rst asserted at SHIFT cycle 4 -> next cycle busy=0, done=0, Diff=0x00, Borrow=0. No done pulse follows; a fresh start then completes normally.
- WIDTH=3, exhaustive A, B in 0..7, Bin in {0,1} (128 cases) -> Diff == (A−B−Bin) mod 8 and Borrow == (A < B+Bin) for every case. Also check WIDTH=1 with all 8 input combinations against the full-subtractor truth table.
